// File: rtl/vending_machine_18105070.sv
// Vending credit FSM. The price is 15 units. Coins are 5 and 10 units, and a cancel code refunds the held credit.
// Latency is 1 cycle: out and change are registered. There is no backpressure: one coin event is accepted every cycle.
// rst is asynchronous: it clears state and outputs at once, without waiting for a clock edge.
module vending_machine_18105070 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in,
    output logic       out,
    output logic [1:0] change
);

    typedef enum logic [1:0] {
        S0  = 2'b00,
        S5  = 2'b01,
        S10 = 2'b10
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_FIVE = 2'b01;
    localparam logic [1:0] COIN_TEN  = 2'b10;
    localparam logic [1:0] CANCEL    = 2'b11;

    localparam logic [1:0] CHG_NONE  = 2'b00;
    localparam logic [1:0] CHG_FIVE  = 2'b01;
    localparam logic [1:0] CHG_TEN   = 2'b10;

    state_t state;

    // out/change default to zero on every edge, so each dispense or refund is a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S0;
            out    <= 1'b0;
            change <= CHG_NONE;
        end else begin
            out    <= 1'b0;
            change <= CHG_NONE;
            case (state)
                S0: begin
                    case (in)
                        COIN_FIVE: state <= S5;
                        COIN_TEN:  state <= S10;
                        default:   state <= S0;
                    endcase
                end
                S5: begin
                    case (in)
                        COIN_NONE: state <= S5;
                        COIN_FIVE: state <= S10;
                        COIN_TEN: begin
                            state <= S0;
                            out   <= 1'b1;
                        end
                        CANCEL: begin
                            state  <= S0;
                            change <= CHG_FIVE;
                        end
                        default: state <= S5;
                    endcase
                end
                S10: begin
                    case (in)
                        COIN_NONE: state <= S10;
                        COIN_FIVE: begin
                            state <= S0;
                            out   <= 1'b1;
                        end
                        // 20 paid against a price of 15: the extra 5 is returned alongside the product.
                        COIN_TEN: begin
                            state  <= S0;
                            out    <= 1'b1;
                            change <= CHG_FIVE;
                        end
                        CANCEL: begin
                            state  <= S0;
                            change <= CHG_TEN;
                        end
                        default: state <= S10;
                    endcase
                end
                default: state <= S0;
            endcase
        end
    end

endmodule

// File: tb/tb_vending_machine_18105070.sv
// Self-checking bench for vending_machine_18105070.
// It applies a table of coin vectors through a scoreboard queue, then runs hand-written reset sequences.
module tb_vending_machine_18105070;

    logic       clk;
    logic       rst;
    logic [1:0] in;
    logic       out;
    logic [1:0] change;

    vending_machine_18105070 dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in),
        .out    (out),
        .change (change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cin;
        logic       exp_out;
        logic [1:0] exp_chg;
        logic [1:0] exp_st;
    } vec_t;

    typedef struct {
        logic       exp_out;
        logic [1:0] exp_chg;
        logic [1:0] exp_st;
        int         idx;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic [1:0] c, input logic o, input logic [1:0] ch, input logic [1:0] s);
        vec_t v;
        v.cin = c; v.exp_out = o; v.exp_chg = ch; v.exp_st = s;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic o, input logic [1:0] ch, input logic [1:0] s);
        logic [1:0] st;
        st = dut.state;
        chk({tag, ".out"},    idx, {1'b0, out}, {1'b0, o});
        chk({tag, ".change"}, idx, change, ch);
        chk({tag, ".state"},  idx, st, s);
    endtask

    // Drive one coin. Its expected result is queued now and compared once the DUT has registered it.
    task automatic step(input logic [1:0] c, input logic o, input logic [1:0] ch, input logic [1:0] s, input int idx);
        sb_t e;
        in = c;
        e.exp_out = o; e.exp_chg = ch; e.exp_st = s; e.idx = idx;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL scoreboard: got empty queue expected entry %0d", idx);
        end else begin
            e = sbq.pop_front();
            chk_all("vec", e.idx, e.exp_out, e.exp_chg, e.exp_st);
        end
    endtask

    initial begin
        // Coin held at 01 straight out of reset: S5, S10, dispense, then S5 again.
        add(2'b01, 0, 2'b00, 2'b01);
        add(2'b01, 0, 2'b00, 2'b10);
        add(2'b01, 1, 2'b00, 2'b00);
        add(2'b01, 0, 2'b00, 2'b01);
        // Idle in S5, then move to S10 and idle there.
        add(2'b00, 0, 2'b00, 2'b01);
        add(2'b00, 0, 2'b00, 2'b01);
        add(2'b00, 0, 2'b00, 2'b01);
        add(2'b01, 0, 2'b00, 2'b10);
        add(2'b00, 0, 2'b00, 2'b10);
        add(2'b00, 0, 2'b00, 2'b10);
        add(2'b00, 0, 2'b00, 2'b10);
        // Cancel from S10 refunds 10. Then idle in S0, and cancel from S0 does nothing.
        add(2'b11, 0, 2'b10, 2'b00);
        add(2'b00, 0, 2'b00, 2'b00);
        add(2'b00, 0, 2'b00, 2'b00);
        add(2'b00, 0, 2'b00, 2'b00);
        add(2'b11, 0, 2'b00, 2'b00);
        // Two tens: dispense plus change 5. The next idle edge drops the pulse.
        add(2'b10, 0, 2'b00, 2'b10);
        add(2'b10, 1, 2'b01, 2'b00);
        add(2'b00, 0, 2'b00, 2'b00);
        // Five then ten: exact payment.
        add(2'b01, 0, 2'b00, 2'b01);
        add(2'b10, 1, 2'b00, 2'b00);
        // Cancel from S5 refunds 5.
        add(2'b01, 0, 2'b00, 2'b01);
        add(2'b11, 0, 2'b01, 2'b00);
        // Ten then five.
        add(2'b10, 0, 2'b00, 2'b10);
        add(2'b01, 1, 2'b00, 2'b00);
        add(2'b00, 0, 2'b00, 2'b00);

        rst = 1'b1;
        in  = 2'bxx;
        #3;
        chk_all("reset", 0, 0, 2'b00, 2'b00);
        in = 2'b01;
        #3;
        rst = 1'b0;

        foreach (tbl[i]) step(tbl[i].cin, tbl[i].exp_out, tbl[i].exp_chg, tbl[i].exp_st, i);

        // Reach S10, then assert reset mid-cycle. It must clear before the next edge.
        step(2'b10, 0, 2'b00, 2'b10, 100);
        #3;
        rst = 1'b1;
        #1;
        chk_all("midrst", 0, 0, 2'b00, 2'b00);
        in = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        chk_all("rsthold", 0, 0, 2'b00, 2'b00);
        #3;
        rst = 1'b0;
        step(2'b01, 0, 2'b00, 2'b01, 101);

        // Reset while a dispense pulse is showing clears out at once.
        step(2'b10, 1, 2'b00, 2'b00, 102);
        #2;
        rst = 1'b1;
        #1;
        chk_all("rstpulse", 0, 0, 2'b00, 2'b00);
        #2;
        rst = 1'b0;
        step(2'b10, 0, 2'b00, 2'b10, 103);
        step(2'b10, 1, 2'b01, 2'b00, 104);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vending_machine_18105070.md
VENDING_MACHINE_18105070 -- requirements
Module: vending_machine_18105070

Interface
REQ-001 The block SHALL have no parameters; price is fixed at 15 units and coins are 5 and 10 units.
REQ-002 clk  input  1  single system clock; all state and outputs update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in  input  2  coin code sampled each rising edge: 00 none, 01 five, 10 ten, 11 cancel/refund.
REQ-005 out  output  1  product dispense flag, registered.
REQ-006 change  output  2  change/refund code, registered: 00 none, 01 five, 10 ten; 11 never driven.

Function
REQ-007 The block SHALL be a credit FSM with three states: S0 (credit 0), S5 (credit 5), S10 (credit 10), 2-bit encoded.
REQ-008 The block SHALL sample `in` once per rising clk edge, giving one coin event per cycle; a coin held for N cycles counts N times.
REQ-009 `out` and `change` SHALL be registered and computed from the pre-edge state and sampled `in`; they are valid for exactly the cycle after the edge, so latency is 1 cycle.
REQ-010 In S0: 00 -> S0; 01 -> S5; 10 -> S10; 11 -> S0; out=0, change=00 in all cases.
REQ-011 In S5: 00 -> S5, out=0, change=00; 01 -> S10, out=0, change=00; 10 -> S0, out=1, change=00; 11 -> S0, out=0, change=01 (refund 5).
REQ-012 In S10: 00 -> S10, out=0, change=00; 01 -> S0, out=1, change=00; 10 -> S0, out=1, change=01; 11 -> S0, out=0, change=10 (refund 10).
REQ-013 On any edge not listed as dispensing or refunding, out SHALL be 0 and change SHALL be 00, so each event produces a single-cycle pulse.
REQ-014 Credit SHALL never exceed 10 in state; overpayment is returned only through `change` in the same cycle as `out`.
REQ-015 X or Z on `in` while rst is high SHALL have no effect.

Reset
REQ-016 When rst is high, the block SHALL immediately (without a clock) force state=S0, out=0 and change=00, independent of clk and `in`.
REQ-017 While rst is high, the block SHALL hold these values; credit accumulated before reset is discarded and not refunded.
REQ-018 On the first rising edge after rst falls, the block SHALL evaluate `in` normally from S0.

Verification
REQ-019 The bench SHALL cover: rst=1 until 6 ns, 10 ns clock period, in=01 held -> edges at 15 ns and 25 ns give S5 then S10 with out=0; edge at 35 ns gives out=1, change=00, S0; edge at 45 ns gives out=0, S5.
REQ-020 The bench SHALL cover: from S0, in=10 then 10 -> second edge gives out=1, change=01, next state S0.
REQ-021 The bench SHALL cover: from S0, in=01 then 10 -> second edge gives out=1, change=00.
REQ-022 The bench SHALL cover: from S10, in=11 -> change=10, out=0, S0; from S5, in=11 -> change=01; from S0, in=11 -> no outputs.
REQ-023 The bench SHALL cover: from S10, assert rst mid-cycle -> out=0, change=00 and state S0 before the next edge; after release, in=01 gives S5.
REQ-024 The bench SHALL cover: in=00 for many cycles in each state -> state held, outputs 0.
